// File: rtl/uart_prog_loader_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_prog_loader_ctrl
// Purpose  : Boot-time program loader between a UART receiver and the core
//            instruction memory. Bytes are packed into 32-bit little-endian
//            words and written to consecutive IMEM word addresses while the
//            core is held in reset. The END_WORD terminator (never written)
//            releases the core.
// Options  : `define PROG_CHECKSUM_EN adds a trailing 32-bit checksum word C
//            after END_WORD; the load succeeds only if sum(words)+C == 0.
// Ports    : wb_clk_i      clock (rising edge)
//            wb_rst_i      synchronous active-high reset
//            prog_en_i     loading enable (level); dropping it aborts a load
//            rx_valid_i    one-cycle byte strobe
//            rx_byte_i     received byte
//            imem_we_o     IMEM write strobe, one cycle per word
//            imem_addr_o   IMEM word address (valid with imem_we_o)
//            imem_wdata_o  IMEM write data   (valid with imem_we_o)
//            core_rst_o    core reset, active high
//            load_done_o   sticky load-success flag
//            load_err_o    sticky load-failure flag
//            word_cnt_o    number of words written so far
// Revision : 1.0 - initial release
// ============================================================================
module uart_prog_loader_ctrl #(
    parameter int          ADDR_W   = 8,
    parameter logic [31:0] END_WORD = 32'h00000FFF
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              prog_en_i,
    input  logic              rx_valid_i,
    input  logic [7:0]        rx_byte_i,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_wdata_o,
    output logic              core_rst_o,
    output logic              load_done_o,
    output logic              load_err_o,
    output logic [ADDR_W:0]   word_cnt_o
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] RECV  = 3'd1;
    localparam logic [2:0] WRITE = 3'd2;
    localparam logic [2:0] DONE  = 3'd3;
    localparam logic [2:0] ERR   = 3'd4;
    localparam logic [2:0] CKSUM = 3'd5;

    // Word count at which IMEM is full (2**ADDR_W).
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    logic [2:0]        state_q, state_d;
    logic [1:0]        lane_q, lane_d;
    logic [31:0]       shift_q, shift_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
`ifdef PROG_CHECKSUM_EN
    logic [31:0]       sum_q, sum_d;
`endif

    logic              byte_acc;
    logic              word_done;
    logic              loading;
    logic [31:0]       word_w;

    // States in which bytes are assembled and prog_en_i can abort the load.
    // WRITE is included so a byte arriving right after a word is kept.
    assign loading   = (state_q == RECV) || (state_q == WRITE) || (state_q == CKSUM);
    assign byte_acc  = rx_valid_i && loading;
    assign word_done = byte_acc && (lane_q == 2'd3);
    // Complete word: the current byte supplies the top lane.
    assign word_w    = {rx_byte_i, shift_q[23:0]};

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        shift_d = shift_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
`ifdef PROG_CHECKSUM_EN
        sum_d   = sum_q;
`endif

        if (byte_acc) begin
            lane_d = lane_q + 2'd1;
            case (lane_q)
                2'd0:    shift_d[7:0]   = rx_byte_i;
                2'd1:    shift_d[15:8]  = rx_byte_i;
                2'd2:    shift_d[23:16] = rx_byte_i;
                default: shift_d        = '0;  // word complete, start fresh
            endcase
        end

        case (state_q)
            IDLE: begin
                if (prog_en_i) state_d = RECV;
            end
            RECV: begin
                if (word_done) begin
                    if (word_w == END_WORD) begin
`ifdef PROG_CHECKSUM_EN
                        state_d = CKSUM;
`else
                        state_d = DONE;
`endif
                    end else if (cnt_q == DEPTH) begin
                        state_d = ERR;
                    end else begin
                        state_d = WRITE;
                        wdata_d = word_w;
                    end
                end
            end
            WRITE: begin
                cnt_d   = cnt_q + 1'b1;
`ifdef PROG_CHECKSUM_EN
                sum_d   = sum_q + wdata_q;
`endif
                state_d = RECV;
            end
`ifdef PROG_CHECKSUM_EN
            CKSUM: begin
                if (word_done) begin
                    state_d = ((sum_q + word_w) == 32'h0) ? DONE : ERR;
                end
            end
`endif
            default: ;  // DONE / ERR hold until reset
        endcase

        // Abort overrides everything above; the write strobe of a WRITE
        // cycle is decoded from the current state and so still completes.
        if (loading && !prog_en_i) begin
            state_d = IDLE;
            lane_d  = 2'd0;
            shift_d = '0;
            cnt_d   = '0;
`ifdef PROG_CHECKSUM_EN
            sum_d   = '0;
`endif
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            lane_q  <= 2'd0;
            shift_q <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
`ifdef PROG_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            shift_q <= shift_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
`ifdef PROG_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    assign imem_we_o    = (state_q == WRITE);
    assign imem_addr_o  = cnt_q[ADDR_W-1:0];
    assign imem_wdata_o = wdata_q;
    assign core_rst_o   = (state_q != DONE);
    assign load_done_o  = (state_q == DONE);
    assign load_err_o   = (state_q == ERR);
    assign word_cnt_o   = cnt_q;

endmodule
`default_nettype wire

// File: doc/uart_prog_loader_ctrl.md
Name: uart_prog_loader_ctrl

Overview:
Boot-time sequencer between the user-project UART receiver and the core instruction memory.
- Assembles received bytes into 32-bit little-endian words and writes them to consecutive IMEM addresses.
- Holds the core in reset while loading and releases it when the end-marker word arrives.
- Sits in the user project next to the UART RX fed from mprj_io[5]; the harness streams the program hex through it.

Parameters:
ADDR_W, 8, IMEM word-address width; capacity DEPTH = 2**ADDR_W words
END_WORD, 32'h00000FFF, terminator word; never written to IMEM

Ports:
wb_clk_i  in  1  single clock, all logic on rising edge
wb_rst_i  in  1  synchronous, active-high reset
prog_en_i  in  1  level; loading enabled (driven from mprj_ready-equivalent)
rx_valid_i  in  1  one-cycle strobe, one byte per strobe
rx_byte_i  in  8  received byte, valid with rx_valid_i
imem_we_o  out  1  IMEM write strobe, one cycle per word
imem_addr_o  out  ADDR_W  IMEM word address
imem_wdata_o  out  32  IMEM write data
core_rst_o  out  1  core reset, active high
load_done_o  out  1  program loaded successfully (sticky)
load_err_o  out  1  load failed (sticky)
word_cnt_o  out  ADDR_W+1  number of words written so far

Behaviour:
- Reset values (wb_rst_i=1 at a clock edge):
  - core_rst_o=1; all other outputs 0.
  - Byte lane=0, shift register=0, state=IDLE.
- Reset is honoured in every state and aborts any load in progress.
- IDLE: rx_valid_i ignored. prog_en_i=1 -> RECV on the next cycle.
- RECV, byte assembly:
  - Each rx_valid_i writes rx_byte_i into lane 0..3; first byte -> bits[7:0], fourth -> bits[31:24].
  - Lane counter wraps 3->0.
- RECV, on the fourth byte (cycle N):
  - Word == END_WORD -> DONE at N+1; no write.
  - Else if word_cnt_o == DEPTH -> ERR at N+1; no write.
  - Else -> WRITE.
- WRITE, cycle N+1:
  - imem_we_o=1 for exactly this cycle.
  - imem_addr_o = word_cnt_o[ADDR_W-1:0]; imem_wdata_o = assembled word.
  - word_cnt_o increments at the end of the cycle; state returns to RECV.
  - A byte strobed during WRITE is accepted into lane 0 (back-to-back bytes are never dropped).
- imem_addr_o and imem_wdata_o are don't-care when imem_we_o=0; the bench checks them only on the strobe.
- prog_en_i=0 in RECV or WRITE:
  - Abort to IDLE; lane and shift register cleared; word_cnt_o cleared.
  - A WRITE in progress that cycle still completes.
- DONE: core_rst_o=0 and load_done_o=1 from the cycle after entry. prog_en_i and rx_valid_i ignored. Exit only by reset.
- ERR: load_err_o=1, core_rst_o stays 1. Exit only by reset.
- load_done_o and load_err_o are never both 1.
- Partial word at abort or reset is discarded.

Optional Feature:
PROG_CHECKSUM_EN
- Defined:
  - A 32-bit running sum (mod 2^32) accumulates every word written to IMEM.
  - After END_WORD, state CKSUM receives one more 4-byte word C.
  - sum+C == 0 -> DONE; otherwise -> ERR.
  - prog_en_i drop in CKSUM aborts to IDLE, same as RECV.
- Not defined: no CKSUM state, no accumulator; END_WORD goes directly to DONE.

Test Plan:
1. Stream bytes 13,00,00,00, B7,02,01,00, FF,0F,00,00 -> exactly two writes: (addr 0, 32'h00000013), (addr 1, 32'h000102B7). word_cnt_o=2, load_done_o=1, core_rst_o falls one cycle after the last byte's state change.
2. Back-to-back strobes every cycle for 3 words + marker -> no byte lost; writes at addr 0,1,2; data matches little-endian assembly.
3. ADDR_W=2: send 5 non-marker words -> 4 writes (addr 0..3). Fifth word -> load_err_o=1, core_rst_o stays 1, no fifth write.
4. prog_en_i dropped after 2 bytes of word 1 (word 0 already written), then re-raised and 2 words + marker sent -> writes restart at addr 0; the partial bytes do not appear in any word.
5. wb_rst_i pulsed mid-word, and again in DONE -> all outputs return to reset values (core_rst_o=1, word_cnt_o=0); a fresh load then succeeds.
6. PROG_CHECKSUM_EN: words 1, 2, marker, then C=32'hFFFFFFFD -> load_done_o=1. Repeat with C=32'hFFFFFFFC -> load_err_o=1, core_rst_o=1.
